inv_sbox_engine: RTL and testbench
==================================

// Module: inv_sbox_engine
// PURPOSE
//  - Iterative InvSubBytes engine for the AES decryption path; the dual of the forward S-box datapath.
//  - Accepts a 128-bit state over a valid/ready handshake.
//  - Substitutes LANES bytes per cycle through a composite-field inverse S-box.
//  - Returns the substituted state over a second valid/ready handshake.
//  - Per-byte datapath:
//      inverse affine (A^-1*x ^ 0x05)
//      -> isomorphic map to GF((2^4)^2)
//      -> GF(2^4) mult/square/lambda stage plus the team's 4-bit GF(2^4) inverse block
//      -> inverse isomorphic map.
// PARAMETERS
//  LANES  4  bytes substituted per cycle; legal 1,2,4,8,16; NCYC = 16/LANES
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    in_data holds a state to process
//  in_ready   out  1    engine can accept a state
//  in_data    in   128  ciphertext-side state; byte0 = [127:120] ... byte15 = [7:0]
//  out_valid  out  1    out_data holds a completed result
//  out_ready  in   1    consumer accepts the result
//  out_data   out  128  InvSubBytes(in_data), same byte order
//  busy       out  1    high in any state other than IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge), values after that edge:
//      in_ready=0, out_valid=0, busy=0, out_data=0, state register=0, cnt=0, FSM=IDLE.
//  - Reset mid-operation: the in-flight state is discarded; no out_valid follows.
//  - FSM states:
//      IDLE: in_ready=1. On in_valid&in_ready: load state reg <= in_data, cnt<=0, go RUN.
//      RUN:  in_ready=0, busy=1.
//            Each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] are replaced by InvSbox(byte).
//            cnt increments by one per cycle.
//            At cnt==NCYC-1 the last group is written, cnt wraps to 0, go DONE.
//      DONE: out_valid=1; out_data = state reg, stable while out_valid&!out_ready.
//            On out_ready go IDLE the following cycle.
//  - No new state is accepted in DONE, so there is no simultaneous accept+deliver.
//  - Throughput: one state per NCYC+2 cycles minimum.
//  - Latency, accept edge to out_valid high: NCYC cycles (4 at LANES=4).
//  - out_ready held high in IDLE/RUN has no effect.
//  - in_valid asserted while busy is ignored; the source holds it until in_ready.
//  - Substitution is purely combinational per lane (no state beyond the state reg).
//  - Each lane must match the FIPS-197 InvSbox for all 256 inputs.
//  - All GF arithmetic is XOR/AND on fixed widths: no carries, no width growth.
//  - Illegal LANES (does not divide 16): elaboration-time error via generate-time $error.
// CONFIGURATION
//  INV_SBOX_PIPE_EN
//   - Defined:
//       Pipeline register between the GF(2^4) inverse stage and the inverse isomorphic map.
//       RUN spends NCYC+1 cycles (one fill cycle); latency = NCYC+1 cycles.
//       cnt tracks the write-back group one cycle behind the read group.
//       The fill cycle writes nothing.
//   - Undefined:
//       Fully combinational lane, timing as in BEHAVIOUR.
//   - Functional results are identical either way.
// TESTING
//  1. FIPS-197 vector: in_data=63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76
//     -> out_data=00 01 02 ... 0F; out_valid 4 cycles after accept (5 with PIPE_EN).
//  2. Exhaustive lane sweep over 16 states covering bytes 00..FF
//     -> matches reference InvSbox table; spot checks 00->52, ED->53, 16->FF, 01->09.
//  3. Backpressure: out_ready=0 for 10 cycles in DONE
//     -> out_valid stays 1, out_data constant, in_ready=0 throughout.
//  4. Reset asserted on the 2nd RUN cycle
//     -> next cycle all outputs 0, FSM IDLE.
//     A fresh state sent after reset produces only its own correct result.
//  5. Back-to-back: in_valid held high with 3 states, out_ready=1
//     -> results in order, one per 6 cycles at LANES=4, no drops or duplicates.
//  6. LANES=1 and LANES=16 builds, vector 1
//     -> latency 16 and 1 cycles respectively, identical out_data.

Source files
------------

// File: rtl/inv_sbox_engine.sv
// Iterative InvSubBytes engine for the AES decryption path.
// A 128-bit state is taken over a valid/ready handshake, LANES bytes are
// replaced per cycle through a composite-field GF((2^4)^2) inverse S-box,
// and the finished state is handed back over a second valid/ready handshake.
// Optional build macro: INV_SBOX_PIPE_EN registers each lane between the
// GF(2^4) inverse stage and the inverse isomorphic map (one extra cycle).

// One byte lane: inverse affine -> iso map -> GF(2^4) inverse core -> inverse iso map
module inv_sbox_lane (
`ifdef INV_SBOX_PIPE_EN
  input  logic       clk,
`endif
  input  logic [7:0] din,
  output logic [7:0] dout
);
  typedef logic [7:0][7:0] mat_t;

  // GF((2^4)^2) built as t^2 + t + LAMBDA over GF(2^4) = GF(2)[x]/(x^4+x+1)
  localparam logic [3:0] LAMBDA = 4'hC;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      p = p ^ (t & {4{b[i]}});
      t = {t[2:0], 1'b0} ^ ({4{t[3]}} & 4'h3);
    end
    return p;
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return gf4_mul(a, a);
  endfunction

  // a^14 = a^-1 in GF(16); maps 0 to 0 as the S-box requires
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gf4_sq(a);
    a4 = gf4_sq(a2);
    a8 = gf4_sq(a4);
    return gf4_mul(gf4_mul(a2, a4), a8);
  endfunction

  // composite-field multiply, [7:4] is the t coefficient
  function automatic logic [7:0] gf8c_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf4_mul(a[7:4], b[7:4]);
    return {hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]),
            gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0])};
  endfunction

  // GF(2) matrix-vector product; column i is m[i]
  function automatic logic [7:0] map8(input mat_t m, input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = r ^ (m[i] & {8{x[i]}});
    return r;
  endfunction

  // Iso map columns are powers of a composite-field root of x^8+x^4+x^3+x+1,
  // found at elaboration so the map always agrees with LAMBDA and gf4_mul.
  function automatic mat_t calc_delta();
    mat_t             m;
    logic [8:0][7:0]  p;
    logic             found;
    m     = '0;
    p     = '0;
    found = 1'b0;
    for (int c = 2; c < 256; c++) begin
      if (!found) begin
        p[0] = 8'h01;
        for (int i = 1; i < 9; i++) p[i] = gf8c_mul(p[i-1], 8'(c));
        if ((p[8] ^ p[4] ^ p[3] ^ p[1] ^ p[0]) == 8'h00) begin
          found = 1'b1;
          for (int i = 0; i < 8; i++) m[i] = p[i];
        end
      end
    end
    return m;
  endfunction

  // Inverse map: column j is the byte whose image is the unit vector e_j
  function automatic mat_t calc_idelta(input mat_t d);
    mat_t       m;
    logic [7:0] y;
    m = '0;
    for (int v = 1; v < 256; v++) begin
      y = map8(d, 8'(v));
      for (int j = 0; j < 8; j++)
        if (y == (8'h01 << j)) m[j] = 8'(v);
    end
    return m;
  endfunction

  localparam mat_t DELTA  = calc_delta();
  localparam mat_t IDELTA = calc_idelta(DELTA);

  logic [7:0] a, c, q, q_r;
  logic [3:0] h, l, d, di;

  // inverse affine, map into the composite field and invert there
  always_comb begin
    a  = {din[6:0], din[7]} ^ {din[4:0], din[7:5]} ^ {din[1:0], din[7:2]} ^ 8'h05;
    c  = map8(DELTA, a);
    h  = c[7:4];
    l  = c[3:0];
    d  = gf4_mul(gf4_sq(h), LAMBDA) ^ gf4_mul(h, l) ^ gf4_sq(l);
    di = gf4_inv(d);
    q  = {gf4_mul(h, di), gf4_mul(h ^ l, di)};
  end

`ifdef INV_SBOX_PIPE_EN
  // mid-lane register; contents only matter once the engine writes them back
  always_ff @(posedge clk) q_r <= q;
`else
  assign q_r = q;
`endif

  assign dout = map8(IDELTA, q_r);
endmodule

// Top: state register, group counter and IDLE/RUN/DONE sequencing
module inv_sbox_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NCYC = (LANES > 0) ? 16 / LANES : 1;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (LANES < 1 || LANES > 16 || (16 % LANES) != 0) begin : g_bad_lanes
    $error("inv_sbox_engine: LANES=%0d must divide 16", LANES);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t                    st;
  logic [127:0]           sreg;
  logic [CW-1:0]          cnt;
  logic [3:0]             rd_base, wr_base;
  logic [LANES-1:0][7:0]  lin, lout;

`ifdef INV_SBOX_PIPE_EN
  // read group runs one cycle ahead of the write-back group (cnt)
  logic [CW-1:0] rd;
  logic          fill;
  assign rd_base = 4'(rd) * 4'(LANES);
`else
  assign rd_base = 4'(cnt) * 4'(LANES);
`endif
  assign wr_base  = 4'(cnt) * 4'(LANES);
  assign out_data = sreg;

  // byte k of the state lives at bits [(15-k)*8 +: 8], i.e. {~k,3'b000}
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [3:0] ri;
    assign ri     = rd_base + 4'(g);
    assign lin[g] = sreg[{~ri, 3'b000} +: 8];
    inv_sbox_lane u_lane (
`ifdef INV_SBOX_PIPE_EN
      .clk  (clk),
`endif
      .din  (lin[g]),
      .dout (lout[g])
    );
  end

  // control FSM with registered handshake outputs and in-place write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef INV_SBOX_PIPE_EN
      rd        <= '0;
      fill      <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sreg     <= in_data;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            st       <= RUN;
`ifdef INV_SBOX_PIPE_EN
            rd       <= '0;
            fill     <= 1'b1;
`endif
          end
        end
        RUN: begin
`ifdef INV_SBOX_PIPE_EN
          rd <= (rd == CW'(NCYC - 1)) ? '0 : rd + 1'b1;
          if (fill) begin
            fill <= 1'b0;
          end else begin
`else
          begin
`endif
            for (int j = 0; j < LANES; j++)
              sreg[{~(wr_base + 4'(j)), 3'b000} +: 8] <= lout[j];
            if (cnt == CW'(NCYC - 1)) begin
              cnt       <= '0;
              out_valid <= 1'b1;
              st        <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            st        <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sbox_engine.sv
// Bench for inv_sbox_engine: three instances (LANES 4, 1, 16) checked against
// an InvSbox table derived from the forward S-box definition (GF(2^8) inverse
// followed by the FIPS-197 affine transform, then inverted as a table).
module tb_inv_sbox_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef INV_SBOX_PIPE_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int LAT0 = 4 + PX;
  localparam int LAT1 = 16 + PX;
  localparam int LAT2 = 1 + PX;

  logic         rst;
  logic [2:0]   iv, ir, ov, orr, bsy;
  logic [127:0] idat [3];
  logic [127:0] odat [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LN = (g == 0) ? 4 : (g == 1) ? 1 : 16;
    inv_sbox_engine #(.LANES(LN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (idat[g]),
      .out_valid (ov[g]),
      .out_ready (orr[g]),
      .out_data  (odat[g]),
      .busy      (bsy[g])
    );
  end

  int nvec = 0;
  int nerr = 0;
  logic [7:0] ref_inv [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vt [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // forward S-box from its definition, then invert the table
  task automatic build_model();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_state(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = ref_inv[d[127 - 8*k -: 8]];
    return r;
  endfunction

  // one full transaction on instance k; lat counts edges from accept to out_valid
  task automatic xact(input int k, input logic [127:0] din, output logic [127:0] dout,
                      output int lat);
    int w;
    dout = '0;
    lat  = -1;
    w = 0;
    while (!ir[k] && w < 50) begin @(posedge clk); #1; w++; end
    if (!ir[k]) begin tmo("in_ready"); return; end
    iv[k]   = 1'b1;
    idat[k] = din;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    w = 0;
    while (!ov[k] && w < 40) begin @(posedge clk); #1; w++; end
    if (!ov[k]) begin tmo("out_valid"); return; end
    lat  = w;
    dout = odat[k];
    orr[k] = 1'b1;
    @(posedge clk); #1;
    orr[k] = 1'b0;
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] FIPS_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  initial begin
    logic [127:0] got, exp, hold, d;
    logic [127:0] b2b [3];
    logic [127:0] gq [$];
    int           tq [$];
    int           lat, idx, cyc, hits;
    logic         acc, oacc;

    rst = 1'b1;
    iv  = '0;
    orr = '0;
    for (int i = 0; i < 3; i++) idat[i] = '0;
    build_model();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst in_ready[%0d]", i), ir[i], 0);
      chk($sformatf("rst out_valid[%0d]", i), ov[i], 0);
      chk($sformatf("rst busy[%0d]", i), bsy[i], 0);
      chk($sformatf("rst out_data[%0d]", i), odat[i], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready after reset", ir[0], 1);

    // vector table: FIPS vector, spot bytes, full 00..FF sweep
    vt.push_back('{FIPS_IN, FIPS_OUT});
    vt.push_back('{128'h00ed1601_63636363_63636363_63636363,
                   128'h5253ff09_00000000_00000000_00000000});
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 16; k++) d[127 - 8*k -: 8] = 8'(16*s + k);
      vt.push_back('{d, ref_state(d)});
    end
    for (int i = 0; i < vt.size(); i++) begin
      xact(0, vt[i].din, got, lat);
      chk($sformatf("vec%0d data", i), got, vt[i].dout);
      chk($sformatf("vec%0d latency", i), lat, LAT0);
    end

    // random states against the model
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      xact(0, d, got, lat);
      chk($sformatf("rand%0d data", i), got, ref_state(d));
    end

    // backpressure: hold out_ready low for 10 cycles in DONE
    d = {$urandom, $urandom, $urandom, $urandom};
    exp = ref_state(d);
    idx = 0;
    while (!ir[0] && idx < 50) begin @(posedge clk); #1; idx++; end
    iv[0] = 1'b1; idat[0] = d;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    idx = 0;
    while (!ov[0] && idx < 40) begin @(posedge clk); #1; idx++; end
    if (!ov[0]) tmo("bp out_valid");
    hold = odat[0];
    chk("bp data", hold, exp);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d out_valid", c), ov[0], 1);
      chk($sformatf("bp%0d out_data", c), odat[0], hold);
      chk($sformatf("bp%0d in_ready", c), ir[0], 0);
    end
    orr[0] = 1'b1;
    @(posedge clk); #1;
    orr[0] = 1'b0;
    chk("bp release out_valid", ov[0], 0);
    chk("bp release busy", bsy[0], 0);

    // reset sampled on the second RUN cycle
    idx = 0;
    while (!ir[0] && idx < 50) begin @(posedge clk); #1; idx++; end
    iv[0] = 1'b1; idat[0] = FIPS_IN;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst in_ready", ir[0], 0);
    chk("midrst out_valid", ov[0], 0);
    chk("midrst busy", bsy[0], 0);
    chk("midrst out_data", odat[0], 0);
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov[0]) hits++;
    end
    chk("midrst no stale out_valid", hits, 0);
    d = {$urandom, $urandom, $urandom, $urandom};
    xact(0, d, got, lat);
    chk("post-reset data", got, ref_state(d));
    chk("post-reset latency", lat, LAT0);

    // back-to-back: in_valid held, out_ready held
    for (int i = 0; i < 3; i++) b2b[i] = {$urandom, $urandom, $urandom, $urandom};
    orr[0] = 1'b1;
    iv[0]  = 1'b1;
    idat[0] = b2b[0];
    idx = 0;
    cyc = 0;
    while (gq.size() < 3 && cyc < 100) begin
      @(negedge clk);
      acc  = iv[0] & ir[0];
      oacc = ov[0] & orr[0];
      if (oacc) begin gq.push_back(odat[0]); tq.push_back(cyc); end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) idat[0] = b2b[idx];
        else iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    orr[0] = 1'b0;
    chk("b2b result count", gq.size(), 3);
    if (gq.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("b2b%0d data", i), gq[i], ref_state(b2b[i]));
      chk("b2b interval 0-1", tq[1] - tq[0], 6 + PX);
      chk("b2b interval 1-2", tq[2] - tq[1], 6 + PX);
    end

    // LANES=1 and LANES=16 builds on the FIPS vector
    xact(1, FIPS_IN, got, lat);
    chk("lanes1 data", got, FIPS_OUT);
    chk("lanes1 latency", lat, LAT1);
    xact(2, FIPS_IN, got, lat);
    chk("lanes16 data", got, FIPS_OUT);
    chk("lanes16 latency", lat, LAT2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
